// File: rtl/inv_test_sequencer_if.sv
// rtl/inv_test_sequencer_if.sv - control, status and DUT-pin bundle for inv_test_sequencer
//
// Signals:
//   start      run request from the host (level sampled in IDLE)
//   busy       run in progress
//   done       one-cycle end-of-run pulse
//   pass       result of the last completed run
//   err_count  saturating mismatch count, ERR_W bits
//   vec_idx    index of the vector currently applied, VIDX_W bits
//   dut_a      drive to the inverter input A
//   dut_a_not  inverter output A_not
// Modports:
//   master     the sequencer
//   slave      host plus the gate under test
interface inv_test_sequencer_if #(
  parameter int N_VECTORS = 8,
  parameter int ERR_W     = 4
);
  localparam int VIDX_W = $clog2(N_VECTORS);

  logic              start;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ERR_W-1:0]  err_count;
  logic [VIDX_W-1:0] vec_idx;
  logic              dut_a;
  logic              dut_a_not;

  modport master (
    input  start, dut_a_not,
    output busy, done, pass, err_count, vec_idx, dut_a
  );

  modport slave (
    output start, dut_a_not,
    input  busy, done, pass, err_count, vec_idx, dut_a
  );
endinterface

// File: rtl/inv_test_sequencer.sv
// rtl/inv_test_sequencer.sv - self-test sequencer for a single-bit inverter under test
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    inv_test_sequencer_if.master: start in, busy/done/pass/err_count/vec_idx out,
//          dut_a out to the gate, dut_a_not in from the gate
//
// A run applies N_VECTORS alternating values (0,1,0,1,...) to the gate, holds each
// for SETTLE_CYC cycles, then spends one SAMPLE cycle comparing A_not against ~A.
// All outputs are registered and updated together with the state.
module inv_test_sequencer #(
  parameter int N_VECTORS  = 8,
  parameter int SETTLE_CYC = 2,
  parameter int ERR_W      = 4,
  localparam int VIDX_W    = $clog2(N_VECTORS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  inv_test_sequencer_if.master bus
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [VIDX_W-1:0] LAST_IDX = VIDX_W'(N_VECTORS - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(SETTLE_CYC - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] settle_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      settle_cnt    <= '0;
      bus.dut_a     <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.pass      <= 1'b0;
      bus.err_count <= '0;
      bus.vec_idx   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state         <= ST_DRIVE;
            settle_cnt    <= '0;
            bus.busy      <= 1'b1;
            bus.pass      <= 1'b0;
            bus.err_count <= '0;
            bus.vec_idx   <= '0;
            bus.dut_a     <= 1'b0;  // vector 0 is always a 0
          end
        end

        ST_DRIVE: begin
          if (settle_cnt == LAST_CNT) begin
            state      <= ST_SAMPLE;
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end

        ST_SAMPLE: begin
          if ((bus.dut_a_not != ~bus.dut_a) && (bus.err_count != ERR_MAX)) begin
            bus.err_count <= bus.err_count + 1'b1;
          end
          if (bus.vec_idx == LAST_IDX) begin
            state    <= ST_DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end else begin
            state       <= ST_DRIVE;
            bus.vec_idx <= bus.vec_idx + 1'b1;
            // dut_a tracks bit 0 of the index, so the next vector is the inverse of this one
            bus.dut_a   <= ~bus.vec_idx[0];
          end
        end

        ST_DONE: begin
          // err_count already carries any increment from the final SAMPLE
          bus.pass  <= (bus.err_count == '0);
          bus.done  <= 1'b0;
          bus.dut_a <= 1'b0;
          state     <= ST_IDLE;
        end

        default: begin
          state    <= ST_IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_test_sequencer.sv
// tb/tb_inv_test_sequencer.sv - self-checking bench for inv_test_sequencer
module tb_inv_test_sequencer;

  localparam int N = 8;
  localparam int S = 2;
  localparam int P = S + 1;
  localparam int L = N * P;

  logic clk = 1'b0;
  logic rst_n;
  int   mode;
  bit   chk_en = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  inv_test_sequencer_if #(.N_VECTORS(N), .ERR_W(4)) bus ();
  inv_test_sequencer_if #(.N_VECTORS(N), .ERR_W(2)) bus2 ();

  // gate models: 0 ideal inverter, 1 stuck-at-0, 2 stuck-at-1, 3 buffer
  assign bus.dut_a_not = (mode == 0) ? ~bus.dut_a :
                         (mode == 1) ? 1'b0 :
                         (mode == 2) ? 1'b1 : bus.dut_a;
  assign bus2.dut_a_not = bus2.dut_a;

  inv_test_sequencer #(.N_VECTORS(N), .SETTLE_CYC(S), .ERR_W(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  inv_test_sequencer #(.N_VECTORS(N), .SETTLE_CYC(S), .ERR_W(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_tests++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Run-position model: m_pos = -1 idle, 0..L-1 busy cycles, L the done cycle.
  int m_pos = -1;
  int m_err = 0;
  int m_err2 = 0;
  int m_hold = 0;
  bit m_pass = 1'b0;
  bit m_pass2 = 1'b0;

  function automatic bit exp_a(input int pos);
    return ((pos / P) % 2) == 1;
  endfunction

  function automatic bit mism(input int md, input bit a);
    bit an;
    case (md)
      0:       an = ~a;
      1:       an = 1'b0;
      2:       an = 1'b1;
      default: an = a;
    endcase
    return an != ~a;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pos <= -1; m_err <= 0; m_err2 <= 0; m_hold <= 0; m_pass <= 1'b0; m_pass2 <= 1'b0;
    end else if (m_pos < 0) begin
      if (bus.start) begin
        m_pos <= 0; m_err <= 0; m_err2 <= 0; m_hold <= 0; m_pass <= 1'b0; m_pass2 <= 1'b0;
      end
    end else if (m_pos < L) begin
      if (m_pos % P == S) begin
        if (mism(mode, exp_a(m_pos)) && m_err < 15) m_err <= m_err + 1;
        if (m_err2 < 3) m_err2 <= m_err2 + 1;
      end
      if (m_pos == L - 1) m_hold <= N - 1;
      m_pos <= m_pos + 1;
    end else begin
      m_pos   <= -1;
      m_pass  <= (m_err == 0);
      m_pass2 <= (m_err2 == 0);
    end
  end

  function automatic bit in_run();
    return (m_pos >= 0) && (m_pos < L);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(bus.busy), int'(in_run()));
      check("done", 32'(bus.done), int'(m_pos == L));
      check("pass", 32'(bus.pass), int'(m_pass));
      check("err_count", 32'(bus.err_count), m_err);
      check("vec_idx", 32'(bus.vec_idx), in_run() ? m_pos / P : m_hold);
      if (m_pos != L) check("dut_a", 32'(bus.dut_a), in_run() ? int'(exp_a(m_pos)) : 0);
      check("busy2", 32'(bus2.busy), int'(in_run()));
      check("done2", 32'(bus2.done), int'(m_pos == L));
      check("pass2", 32'(bus2.pass), int'(m_pass2));
      check("err_count2", 32'(bus2.err_count), m_err2);
    end
  end

  task automatic run_once(output int busy_cyc, output logic [23:0] a_hist,
                          output int done_cnt, output int first_err);
    busy_cyc = 0; a_hist = '0; done_cnt = 0; first_err = -1;
    @(negedge clk); bus.start = 1'b1; bus2.start = 1'b1;
    @(negedge clk); bus.start = 1'b0; bus2.start = 1'b0;
    for (int i = 0; i < 100 && done_cnt == 0; i++) begin
      if (bus.busy) begin
        if (busy_cyc == 0) first_err = int'(bus.err_count);
        if (busy_cyc < 24) a_hist[busy_cyc] = bus.dut_a;
        busy_cyc++;
      end
      if (bus.done) done_cnt++;
      if (done_cnt == 0) @(negedge clk);
    end
    check("done_seen", 32'(done_cnt), 1);
  endtask

  int          bc, dc, fe, idle_cnt;
  logic [23:0] ah;
  bit          found;

  initial begin
    mode = 0; rst_n = 1'b0; bus.start = 1'b0; bus2.start = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_err", 32'(bus.err_count), 0);
    check("rst_vec", 32'(bus.vec_idx), 0);
    check("rst_pass", 32'(bus.pass), 0);
    check("rst_dut_a", 32'(bus.dut_a), 0);
    rst_n = 1'b1;

    // ideal inverter
    run_once(bc, ah, dc, fe);
    check("ideal_busy_len", 32'(bc), 24);
    check("ideal_a_pattern", 32'(ah), 32'hE38E38);
    @(negedge clk);
    check("ideal_pass", 32'(bus.pass), 1);
    check("ideal_err", 32'(bus.err_count), 0);
    check("ideal_vec", 32'(bus.vec_idx), 7);
    check("sat_err2", 32'(bus2.err_count), 3);
    check("sat_pass2", 32'(bus2.pass), 0);

    // stuck-at-0
    mode = 1;
    run_once(bc, ah, dc, fe);
    @(negedge clk);
    check("sa0_err", 32'(bus.err_count), 4);
    check("sa0_pass", 32'(bus.pass), 0);

    // stuck-at-1
    mode = 2;
    run_once(bc, ah, dc, fe);
    @(negedge clk);
    check("sa1_err", 32'(bus.err_count), 4);
    check("sa1_pass", 32'(bus.pass), 0);

    // ideal again: count clears on start
    mode = 0;
    run_once(bc, ah, dc, fe);
    check("rerun_first_err", 32'(fe), 0);
    @(negedge clk);
    check("rerun_pass", 32'(bus.pass), 1);
    check("rerun_err", 32'(bus.err_count), 0);

    // start held for 60 sampling edges
    dc = 0; idle_cnt = 0;
    bus.start = 1'b1; bus2.start = 1'b1;
    for (int i = 0; i < 110; i++) begin
      @(negedge clk);
      if (bus.done) dc++;
      if (i <= 76 && !bus.busy && !bus.done) idle_cnt++;
      if (i == 59) begin bus.start = 1'b0; bus2.start = 1'b0; end
    end
    check("held_done_pulses", 32'(dc), 3);
    check("held_idle_gaps", 32'(idle_cnt), 2);

    // reset mid-run at vec_idx 3
    @(negedge clk); bus.start = 1'b1; bus2.start = 1'b1;
    @(negedge clk); bus.start = 1'b0; bus2.start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (bus.vec_idx == 3) found = 1'b1;
      else @(negedge clk);
    end
    check("reach_vec3", 32'(found), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_done", 32'(bus.done), 0);
    check("mid_rst_pass", 32'(bus.pass), 0);
    check("mid_rst_err", 32'(bus.err_count), 0);
    check("mid_rst_vec", 32'(bus.vec_idx), 0);
    check("mid_rst_dut_a", 32'(bus.dut_a), 0);
    check("mid_rst_err2", 32'(bus2.err_count), 0);
    dc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) dc++;
    end
    check("mid_rst_no_done", 32'(dc), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inv_test_sequencer.md
Name: inv_test_sequencer

Overview:
- Self-test controller for a single-bit inverter gate under test (DUT).
- Drives the DUT input through a fixed alternating vector sequence and waits a programmable settle time per vector.
- Samples the DUT output, counts mismatches against the expected inverted value, and reports pass/fail.
- Sits beside the gate-level lab blocks; the DUT A/A_not pins connect directly to dut_a/dut_a_not.

Parameters:
- N_VECTORS, 8, number of vectors applied per test run; minimum 2.
- SETTLE_CYC, 2, cycles dut_a is held before sampling; minimum 1.
- ERR_W, 4, width of the saturating error counter.
- VIDX_W, $clog2(N_VECTORS), width of the vector index; derived, not overridden.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  level-sampled run request; acted on only in IDLE.
- dut_a  output  1  drive to the DUT input A.
- dut_a_not  input  1  DUT output A_not.
- busy  output  1  high while a run is in progress.
- done  output  1  one-cycle pulse at the end of a run.
- pass  output  1  result of the last completed run; held until the next start.
- err_count  output  ERR_W  mismatches in the current or last run, saturating.
- vec_idx  output  VIDX_W  index of the vector currently applied.

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; dut_a=0, busy=0, done=0, pass=0, err_count=0, vec_idx=0, settle counter=0.
  - Reset mid-run aborts the run immediately; no done pulse is produced.
- States: IDLE, DRIVE, SAMPLE, DONE. State is registered.
  - busy = (state==DRIVE or SAMPLE).
  - done = (state==DONE).
- IDLE, start=1 at an edge:
  - Next state DRIVE; clear err_count, vec_idx, and settle counter; pass cleared to 0.
  - busy rises in the cycle after start is sampled.
- DRIVE:
  - dut_a = vec_idx[0], giving the sequence 0,1,0,1,...
  - The settle counter counts 0..SETTLE_CYC-1. At count SETTLE_CYC-1, go to SAMPLE and reset the counter.
- SAMPLE (exactly one cycle):
  - dut_a is held at its DRIVE value.
  - If dut_a_not != ~dut_a, increment err_count, saturating at 2^ERR_W-1.
  - If vec_idx==N_VECTORS-1, go to DONE. Otherwise increment vec_idx and go to DRIVE.
- DONE (exactly one cycle):
  - pass <= (err_count==0) is registered using the final count, including any increment from the last SAMPLE.
  - Next state IDLE. dut_a returns to 0 in IDLE.
- Run length: busy is high for N_VECTORS*(SETTLE_CYC+1) cycles (24 at defaults); done asserts in the following cycle.
- start is ignored in DRIVE, SAMPLE and DONE; it is not queued.
- If start is held high continuously, a new run begins after exactly one IDLE cycle.
- err_count and vec_idx hold their last values in IDLE until the next start.
- dut_a_not is sampled only in SAMPLE; its value in other states has no effect.

Test Plan:
- Ideal inverter model (dut_a_not=~dut_a), defaults, 1-cycle start pulse -> busy high 24 cycles, dut_a toggles 0/1 every 3 cycles, done pulse 1 cycle, pass=1, err_count=0, vec_idx=7.
- Stuck-at-0 DUT (dut_a_not=0) -> the 4 vectors with dut_a=0 mismatch; err_count=4, pass=0 after done.
- Stuck-at-1 DUT -> err_count=4, pass=0. A subsequent run with the ideal model clears err_count to 0 on start and ends with pass=1.
- start held high for 60 cycles, ideal DUT -> back-to-back runs separated by one IDLE cycle; start during busy does not restart the run; each run produces exactly one done pulse.
- rst_n driven low for 1 cycle while vec_idx=3 -> on the next cycle busy=0, done=0, pass=0, err_count=0, vec_idx=0, dut_a=0; no done pulse follows.
- ERR_W=2, buffer DUT (dut_a_not=dut_a, all 8 vectors fail) -> err_count counts 1,2,3 then saturates at 3; pass=0.
